// File: rtl/r2r_wave_gen_if.sv
// Command/sample bundle between the configuring master and the R2R waveform source.
// The master drives run and the command port; the generator returns sample and wrap.
interface r2r_wave_gen_if;
    logic       run;
    logic       cmd_valid;
    logic [1:0] cmd_sel;
    logic [7:0] cmd_data;
    logic [7:0] sample;
    logic       wrap;

    modport master (
        output run, cmd_valid, cmd_sel, cmd_data,
        input  sample, wrap
    );

    modport slave (
        input  run, cmd_valid, cmd_sel, cmd_data,
        output sample, wrap
    );
endinterface

// File: rtl/r2r_wave_gen.sv
// Phase-accumulator waveform source (saw/triangle/square/16-entry LUT) with amplitude
// scaling, producing the 8-bit sample stream for the downstream R2R DAC controller.
module r2r_wave_gen #(
    parameter int         PHASE_W = 16,
    parameter logic [7:0] AMP_RST = 8'hFF
) (
    input logic           clk,
    input logic           n_rst,
    r2r_wave_gen_if.slave bus
);

    typedef enum logic [1:0] {MODE_SAW, MODE_TRI, MODE_SQR, MODE_LUT} mode_t;

    logic [7:0]         step;
    logic [7:0]         amp;
    mode_t              mode;
    logic [3:0]         wptr;
    logic [7:0]         lut [16];

    logic [PHASE_W-1:0] phase_p0;
    logic               ovf_p0;
    logic [7:0]         wave_p1;
    logic [7:0]         amp_p1;
    logic               ovf_p1;
    logic [7:0]         sample_p2;
    logic               wrap_p2;

    logic               clr;
    logic [PHASE_W:0]   sum;
    logic [PHASE_W-1:0] phase_nxt;
    logic               ovf_nxt;
    logic [7:0]         idx;

    function automatic logic [7:0] shape(input logic [7:0] p, input mode_t m,
                                         input logic [7:0] lv);
        logic [7:0] w;
        case (m)
            MODE_SAW: w = p;
            MODE_TRI: w = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            MODE_SQR: w = p[7] ? 8'hFF : 8'h00;
            default:  w = lv;
        endcase
        return w;
    endfunction

    // Gain of (a+1)/256 so a=FF is an exact passthrough.
    function automatic logic [7:0] scale(input logic [7:0] w, input logic [7:0] a);
        logic [16:0] prod;
        prod = {9'd0, w} * ({9'd0, a} + 17'd1);
        return prod[15:8];
    endfunction

    assign clr = bus.cmd_valid && (bus.cmd_sel == 2'd1) && bus.cmd_data[7];
    assign sum = {1'b0, phase_p0} + {{(PHASE_W-7){1'b0}}, step};
    assign idx = phase_p0[PHASE_W-1 -: 8];

    always_comb begin
        phase_nxt = phase_p0;
        ovf_nxt   = 1'b0;
        if (clr) begin
            phase_nxt = '0;
        end else if (bus.run) begin
            phase_nxt = sum[PHASE_W-1:0];
            ovf_nxt   = sum[PHASE_W];
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            step <= '0;
            amp  <= AMP_RST;
            mode <= MODE_SAW;
            wptr <= '0;
            for (int i = 0; i < 16; i++) lut[i] <= '0;
        end else if (bus.cmd_valid) begin
            case (bus.cmd_sel)
                2'd0: step <= bus.cmd_data;
                2'd1: begin
                    mode <= mode_t'(bus.cmd_data[1:0]);
                    wptr <= '0;
                end
                2'd2: begin
                    lut[wptr] <= bus.cmd_data;
                    wptr      <= wptr + 4'd1;
                end
                default: amp <= bus.cmd_data;
            endcase
        end
    end

    // p0: phase accumulator and its carry
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            phase_p0 <= '0;
            ovf_p0   <= 1'b0;
        end else begin
            phase_p0 <= phase_nxt;
            ovf_p0   <= ovf_nxt;
        end
    end

    // p1: shaped wave; amp travels with it so gain and shape changes land together
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            wave_p1 <= '0;
            amp_p1  <= '0;
            ovf_p1  <= 1'b0;
        end else begin
            wave_p1 <= shape(idx, mode, lut[idx[7:4]]);
            amp_p1  <= amp;
            ovf_p1  <= ovf_p0;
        end
    end

    // p2: scaled sample, wrap aligned with the first post-wrap sample
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            sample_p2 <= '0;
            wrap_p2   <= 1'b0;
        end else begin
            sample_p2 <= scale(wave_p1, amp_p1);
            wrap_p2   <= ovf_p1;
        end
    end

    assign bus.sample = sample_p2;
    assign bus.wrap   = wrap_p2;

endmodule

// File: tb/tb_r2r_wave_gen.sv
// Bench for r2r_wave_gen: per-cycle comparison against an arithmetic reference model,
// a table of held-phase vectors, and directed ramp/LUT/hold/async-reset sequences.
module tb_r2r_wave_gen;

    logic clk = 1'b0;
    logic n_rst;
    always #50 clk = ~clk;

    r2r_wave_gen_if bus();

    r2r_wave_gen #(.PHASE_W(16), .AMP_RST(8'hFF)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int m_phase, m_step, m_mode, m_amp, m_wptr;
    int m_lut [16];
    int q_s [$];
    int q_w [$];
    int exp_s, exp_w;

    typedef struct {
        int mode;
        int p;
        int amp;
        int expv;
    } vec_t;
    vec_t vt [10];

    function automatic int m_shape(int p, int mode);
        case (mode)
            0: return p;
            1: return (p < 128) ? 2 * p : 511 - 2 * p;
            2: return (p >= 128) ? 255 : 0;
            default: return m_lut[p / 16];
        endcase
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_step = 0; m_mode = 0; m_amp = 255; m_wptr = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 0;
        q_s = {0};
        q_w = {0, 0};
        exp_s = 0; exp_w = 0;
    endtask

    // One clock edge of the reference: the value computed now appears on sample
    // after the next edge, the carry appears on wrap two edges later.
    task automatic model_edge();
        int v, nxt, clr, c;
        v   = (m_shape(m_phase / 256, m_mode) * (m_amp + 1)) / 256;
        nxt = m_phase + m_step;
        clr = (bus.cmd_valid && bus.cmd_sel == 2'd1 && bus.cmd_data[7]) ? 1 : 0;
        c   = (bus.run && nxt > 65535 && clr == 0) ? 1 : 0;
        q_s.push_back(v);
        exp_s = q_s.pop_front();
        q_w.push_back(c);
        exp_w = q_w.pop_front();
        if (clr != 0) m_phase = 0;
        else if (bus.run) m_phase = nxt % 65536;
        if (bus.cmd_valid) begin
            case (bus.cmd_sel)
                2'd0: m_step = bus.cmd_data;
                2'd1: begin m_mode = bus.cmd_data % 4; m_wptr = 0; end
                2'd2: begin m_lut[m_wptr] = bus.cmd_data; m_wptr = (m_wptr + 1) % 16; end
                default: m_amp = bus.cmd_data;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("sample", bus.sample, exp_s);
        chk("wrap", bus.wrap, exp_w);
    endtask

    task automatic cmd(input logic [1:0] sel, input logic [7:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = sel;
        bus.cmd_data  = data;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Clear phase in the given mode, run to p*256, then stop and let the pipe settle.
    task automatic seek(input int mode, input int p);
        logic [7:0] mc;
        mc = 8'h80 | 8'(mode);
        bus.run = 1'b0;
        cmd(2'd1, mc);
        cmd(2'd0, 8'h80);
        bus.run = 1'b1;
        repeat (2 * p) tick();
        bus.run = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        int wraps;
        logic [7:0] d;

        vt[0] = '{1, 8'h40, 8'hFF, 8'h80};
        vt[1] = '{1, 8'hC0, 8'hFF, 8'h7F};
        vt[2] = '{1, 8'h7F, 8'hFF, 8'hFE};
        vt[3] = '{1, 8'h80, 8'hFF, 8'hFF};
        vt[4] = '{0, 8'hFF, 8'h7F, 8'h7F};
        vt[5] = '{0, 8'h80, 8'h7F, 8'h40};
        vt[6] = '{0, 8'hFF, 8'h00, 8'h00};
        vt[7] = '{2, 8'h80, 8'hFF, 8'hFF};
        vt[8] = '{2, 8'h7F, 8'hFF, 8'h00};
        vt[9] = '{0, 8'hA5, 8'hFF, 8'hA5};

        n_rst = 1'b1;
        bus.run = 1'b0; bus.cmd_valid = 1'b0; bus.cmd_sel = '0; bus.cmd_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_sample", bus.sample, 0);
        chk("reset_wrap", bus.wrap, 0);
        n_rst = 1'b0;
        model_reset();

        // Saw ramp, step 0x80: one wrap every 512 cycles, sample 0 when it fires
        cmd(2'd0, 8'h80);
        bus.run = 1'b1;
        wraps = 0;
        for (int i = 0; i < 1030; i++) begin
            tick();
            if (bus.wrap) begin
                wraps++;
                chk("wrap_sample_zero", bus.sample, 0);
            end
        end
        chk("wrap_count", wraps, 2);

        // Hold mid-ramp, then resume
        seek(0, 8'h37);
        chk("hold_value", bus.sample, 8'h37);
        repeat (5) tick();
        chk("hold_still", bus.sample, 8'h37);
        chk("hold_nowrap", bus.wrap, 0);
        bus.run = 1'b1;
        repeat (20) tick();

        for (int i = 0; i < 10; i++) begin
            cmd(2'd3, 8'(vt[i].amp));
            seek(vt[i].mode, vt[i].p);
            chk($sformatf("table%0d", i), bus.sample, vt[i].expv);
        end

        // LUT: 16 writes, then a 17th that lands on entry 0
        cmd(2'd3, 8'hFF);
        cmd(2'd1, 8'h83);
        for (int i = 0; i < 16; i++) cmd(2'd2, 8'(i * 8'h11));
        cmd(2'd2, 8'hAA);
        for (int i = 0; i < 16; i++) begin
            seek(3, i * 16 + 8);
            chk($sformatf("lut%0d", i), bus.sample, (i == 0) ? 8'hAA : i * 8'h11);
        end
        cmd(2'd0, 8'hFF);
        bus.run = 1'b1;
        repeat (300) tick();

        for (int i = 0; i < 3000; i++) begin
            bus.run = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 3) begin
                d = 8'($urandom_range(0, 255));
                cmd(2'($urandom_range(0, 3)), d);
            end else begin
                tick();
            end
        end

        // Async reset between edges while square is high
        bus.run = 1'b0;
        cmd(2'd3, 8'hFF);
        cmd(2'd1, 8'h82);
        cmd(2'd0, 8'h80);
        bus.run = 1'b1;
        repeat (300) tick();
        chk("square_high", bus.sample, 8'hFF);
        #20 n_rst = 1'b1;
        #1;
        chk("async_rst_sample", bus.sample, 0);
        chk("async_rst_wrap", bus.wrap, 0);
        @(negedge clk);
        n_rst = 1'b0;
        bus.run = 1'b0;
        model_reset();
        bus.run = 1'b1;
        repeat (10) tick();
        chk("post_rst_step0", bus.sample, 0);
        bus.run = 1'b0;
        cmd(2'd0, 8'h80);
        bus.run = 1'b1;
        repeat (2 * 8'h20) tick();
        bus.run = 1'b0;
        repeat (3) tick();
        chk("post_rst_defaults", bus.sample, 8'h20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/r2r_wave_gen.md
Name: r2r_wave_gen

Overview:
Waveform source sitting directly upstream of the R2R DAC controller; produces the 8-bit sample stream that the controller drives onto the R2R ladder via its external-data path. A phase accumulator is shaped into saw, triangle, square or a 16-entry user LUT, then amplitude-scaled. Configured through a byte-wide command port driven from ui_in, and runs from the 10 MHz design clock.

Parameters:
PHASE_W, 16, phase accumulator width (min 9); waveform index = phase[PHASE_W-1 -: 8]
AMP_RST, 8'hFF, amplitude register reset value (unity gain)

Ports:
clk  input  1  design clock, 10 MHz
n_rst  input  1  asynchronous reset, active-high (despite the name)
run  input  1  1 = phase accumulator advances every clk; 0 = phase holds
cmd_valid  input  1  command strobe, one command accepted per cycle it is high; no backpressure
cmd_sel  input  2  0 = step, 1 = mode/control, 2 = LUT write, 3 = amplitude
cmd_data  input  8  command payload
sample  output  8  shaped, scaled sample; feeds the DAC controller data input
wrap  output  1  one-cycle pulse aligned with the first sample of each period

Behaviour:
- Reset (async, n_rst=1): phase=0, step=0, mode=0, amp=AMP_RST, lut[0..15]=0, wptr=0, all pipeline regs=0, sample=0, wrap=0.
- Commands, registered on the clk edge where cmd_valid=1:
  - sel 0: step <= cmd_data.
  - sel 1: mode <= cmd_data[1:0]; wptr <= 0; if cmd_data[7]=1, phase <= 0, overriding the run increment that cycle.
  - sel 2: lut[wptr] <= cmd_data; wptr <= wptr+1, wrapping 15 -> 0.
  - sel 3: amp <= cmd_data.
  - New values take effect from the next cycle; an increment in the same cycle as a step write uses the old step.
- Phase: when run=1, phase <= phase + zero-extended step, modulo 2^PHASE_W. ovf = carry out of that add. When run=0, phase holds and ovf=0.
- Stage 1 (registered), with p = phase[PHASE_W-1 -: 8]:
  - mode 0 (saw): p
  - mode 1 (triangle): p[7] ? ~{p[6:0],0} : {p[6:0],0}
  - mode 2 (square): p[7] ? 8'hFF : 8'h00
  - mode 3 (LUT): lut[p[7:4]]
  - ovf is registered alongside the wave value.
- Stage 2 (registered): sample <= (wave * (amp+1)) >> 8, with a 9x8 unsigned multiply and the result taking bits [15:8]. amp=FF is exact passthrough; amp=00 gives (wave>>8) = 0.
- Latency:
  - sample reflects the phase register value from 2 cycles earlier.
  - wrap is the ovf flag delayed so it is asserted with the sample computed from the post-wrap phase.
  - Mode and amp changes are visible on sample 2 cycles later.
- The pipeline keeps clocking when run=0, so sample settles to the held phase within 2 cycles.
- A LUT write to an entry currently being read gives the new value on the next stage-1 evaluation; no hazard stall.
- Reset mid-operation clears everything immediately, including the LUT; sample=0 until run resumes and the pipeline refills.

Test Plan:
- Reset, then write step=0x80, run=1 in saw mode -> sample rises by 1 every 2 cycles (0,0,1,1,...,FF,FF,0); wrap pulses every 512 cycles, coincident with sample returning to 0x00.
- Mode 1 triangle, phase held so p=0x40 then p=0xC0 -> sample 0x80 then 0x7F; p=0x7F -> 0xFE, p=0x80 -> 0xFF.
- Mode 1 write with cmd_data=0x83, then 16 LUT writes 0x00,0x11,...,0xFF, step=0xFF -> sample steps through the LUT values in index order. A 17th write overwrites lut[0].
- Saw with amp=0x7F -> p=0xFF gives 0x7F and p=0x80 gives 0x40; amp=0x00 -> sample constant 0.
- Set run=0 mid-ramp at p=0x37 -> sample holds 0x37 after 2 cycles and wrap stays 0; run=1 resumes from 0x37.
- Assert n_rst asynchronously between clock edges during square output -> sample=0 immediately; step=0, amp=FF and mode=0 read back through behaviour after release.
